// File: rtl/fp_sigdiv_seq_if.sv
// Request/result bundle for the sequential significand divider / square-root unit.
// The requester drives the operands and controls; the unit returns status and result.
interface fp_sigdiv_seq_if;
    logic        clear;
    logic        enable;
    logic        op_div;
    logic        op_sqrt;
    logic        fmt;
    logic        exp_odd;
    logic [52:0] a;
    logic [52:0] b;
    logic        busy;
    logic        ready;
    logic [54:0] q;
    logic        sticky;

    modport master (
        output clear, enable, op_div, op_sqrt, fmt, exp_odd, a, b,
        input  busy, ready, q, sticky
    );

    modport slave (
        input  clear, enable, op_div, op_sqrt, fmt, exp_odd, a, b,
        output busy, ready, q, sticky
    );
endinterface

// File: rtl/fp_sigdiv_seq.sv
// Radix-2 restoring significand divider and radix-4-fed square root, one result bit per cycle.
// Produces 55 bits for double (fmt=1) or 26 left-aligned bits for single (fmt=0), plus sticky.
module fp_sigdiv_seq (
    input  logic           clock,
    input  logic           reset,
    fp_sigdiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [5:0]   count;
    logic         fmt_l;
    logic         sqrt_l;
    logic [52:0]  b_l;
    logic [56:0]  rem;
    logic [54:0]  quo;
    logic [109:0] rad;

    logic         busy_r;
    logic         ready_r;
    logic [54:0]  q_r;
    logic         sticky_r;

    logic         start;
    logic         start_sqrt;
    logic         div_ge;
    logic [56:0]  div_diff;
    logic [56:0]  div_sel;
    logic [58:0]  sq_pr;
    logic [58:0]  sq_trial;
    logic         sq_ge;
    logic [56:0]  rem_next;
    logic [54:0]  quo_next;

    // Divide wins when both op bits are set.
    assign start      = bus.enable && (bus.op_div || bus.op_sqrt) && (state != BUSY);
    assign start_sqrt = bus.op_sqrt && !bus.op_div;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        div_ge   = rem >= {4'b0000, b_l};
        div_diff = rem - {4'b0000, b_l};
        div_sel  = div_ge ? div_diff : rem;
        sq_pr    = {rem, rad[109:108]};
        sq_trial = {2'b00, quo, 2'b01};
        sq_ge    = sq_pr >= sq_trial;
        rem_next = div_sel << 1;
        quo_next = {quo[53:0], div_ge};
        if (sqrt_l) begin
            // The true difference fits in 57 bits, so low-bit subtraction is exact.
            rem_next = sq_ge ? (sq_pr[56:0] - sq_trial[56:0]) : sq_pr[56:0];
            quo_next = {quo[53:0], sq_ge};
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            fmt_l    <= 1'b0;
            sqrt_l   <= 1'b0;
            b_l      <= '0;
            rem      <= '0;
            quo      <= '0;
            rad      <= '0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            q_r      <= '0;
            sticky_r <= 1'b0;
        end else if (bus.clear) begin
            state   <= IDLE;
            count   <= '0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            // Status outputs trail the state by one edge, giving the documented latency.
            busy_r  <= (state == BUSY);
            ready_r <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= BUSY;
                        count  <= bus.fmt ? 6'd54 : 6'd25;
                        fmt_l  <= bus.fmt;
                        sqrt_l <= start_sqrt;
                        b_l    <= bus.b;
                        quo    <= '0;
                        rem    <= start_sqrt ? 57'd0 : {4'b0000, bus.a};
                        // Radicand (a or 2a) placed so its top pair is consumed first.
                        rad    <= start_sqrt
                                  ? {(bus.exp_odd ? {bus.a, 1'b0} : {1'b0, bus.a}), 56'd0}
                                  : 110'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    rad <= {rad[107:0], 2'b00};
                    if (count == 6'd0) begin
                        state    <= DONE;
                        q_r      <= fmt_l ? quo_next : {quo_next[25:0], 29'd0};
                        sticky_r <= |rem_next;
                    end else begin
                        count <= count - 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.ready  = ready_r;
    assign bus.q      = q_r;
    assign bus.sticky = sticky_r;
endmodule

// File: doc/fp_sigdiv_seq.md
FP_SIGDIV_SEQ -- requirements
Module: fp_sigdiv_seq

Interface
REQ-001 Parameter: none; significand width fixed at 53 bits; quotient/root width fixed at 55 bits.
REQ-002 reset  input  1  synchronous, active-low.
REQ-003 clock  input  1  all state updates on rising edge.
REQ-004 clear  input  1  synchronous abort, active-high.
REQ-005 enable  input  1  start request, sampled every edge.
REQ-006 op_div  input  1  select divide a/b.
REQ-007 op_sqrt  input  1  select square root of a.
REQ-008 fmt  input  1  0 = single (24-bit significand in a[52:29]), 1 = double (53-bit in a[52:0]).
REQ-009 exp_odd  input  1  sqrt only; 1 = radicand is 2*a.
REQ-010 a  input  53  normalized dividend/radicand, hidden bit at [52]; a[28:0] zero when fmt=0.
REQ-011 b  input  53  normalized divisor, hidden bit at [52]; b[28:0] zero when fmt=0.
REQ-012 busy  output  1  high while iterating.
REQ-013 ready  output  1  single-cycle completion pulse.
REQ-014 q  output  55  quotient/root, MSB = integer bit (weight 2^0).
REQ-015 sticky  output  1  1 = final partial remainder nonzero.

Function
REQ-016 States: IDLE, BUSY, DONE; reset, clear -> IDLE.
REQ-017 Iteration count N = 55 (fmt=1) or 26 (fmt=0); captured with operands at start.
REQ-018 Start: enable=1 in IDLE or DONE with op_div or op_sqrt set -> latch a, b, fmt, op, exp_odd; go BUSY; counter = N-1.
REQ-019 enable=1 with neither op set: ignored, no state change.
REQ-020 op_div and op_sqrt both set: divide performed.
REQ-021 enable while BUSY: ignored; in-flight operation unaffected.
REQ-022 BUSY: one result bit per cycle, MSB first; counter decrements; at counter 0 -> DONE next edge.
REQ-023 DONE: ready=1 exactly one cycle, then IDLE unless new start accepted that cycle.
REQ-024 Latency: enable sampled at edge k -> ready high during cycle after edge k+N+1; busy high cycles after edges k+1..k+N.
REQ-025 Divide (restoring): R0 = a (56-bit container); each step: R>=B -> bit 1, R=R-B; else bit 0; then R=R<<1. Value q = floor(A*2^(N-1)/B) in N bits.
REQ-026 Sqrt (restoring, 2 radicand bits/step): M = X*2^(2N-2), X = sig(a) or 2*sig(a); R=(R<<2)|next two bits of M; T=R-((Q<<2)|1); T>=0 -> R=T, Q=(Q<<1)|1; else Q=Q<<1.
REQ-027 fmt=0 result left-aligned: q[54:29] = 26-bit result, q[28:0] = 0.
REQ-028 sticky = (final R != 0), registered with q.
REQ-029 q, sticky updated only on entry to DONE; held until next DONE; not cleared by clear.
REQ-030 clear in BUSY: -> IDLE next edge, busy=0, no ready pulse, q/sticky keep previous values.
REQ-031 clear and enable same edge: clear wins, no start.
REQ-032 Partial remainder and Q registers sized so no overflow for a,b in [1,2), X in [1,4).

Reset
REQ-033 reset=0 at edge -> state IDLE, busy=0, ready=0, q=0, sticky=0, counter=0, latched operands=0; overrides clear and enable.
REQ-034 Reset mid-BUSY: operation abandoned, no ready pulse after release.
REQ-035 First start accepted at first edge with reset=1.

Verification
REQ-036 fmt=1 div a=53'h10000000000000, b=53'h10000000000000 -> q=55'h40000000000000, sticky=0, ready 56 cycles after enable edge.
REQ-037 fmt=1 div a=1.0, b=53'h18000000000000 (1.5) -> q=55'h2AAAAAAAAAAAAA, sticky=1.
REQ-038 fmt=1 sqrt a=1.0: exp_odd=0 -> q=55'h40000000000000, sticky=0; exp_odd=1 -> q[54:51]=4'b1011, sticky=1.
REQ-039 fmt=0 div a=53'h18000000000000, b=1.0 -> q[54:29]=26'h3000000, q[28:0]=0, sticky=0, ready 27 cycles after enable.
REQ-040 Start, enable again at BUSY cycle 5, then clear at cycle 10 -> no ready, busy=0 next cycle, q unchanged; new start then completes normally.
REQ-041 reset=0 at BUSY cycle 20 -> all outputs zero, no ready; restart after release gives REQ-036 result.
